// File: rtl/mult_share_arb.sv
// Shares one pipelined 17x8 twiddle multiplier between NREQ requesters using a round-robin grant.
// Define MULT_SHARE_PRIO0_EN to give requester 0 fixed top priority over a 1..NREQ-1 rotation.
module mult_share_arb #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 4,
  parameter int IDW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [17*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [16:0]       mul_a,
  output logic [7:0]        mul_b,
  input  logic [16:0]       mul_p,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [16:0]       rsp_data,
  output logic              busy
);

  // Handshake: requester i transfers an operand pair in any cycle where
  // req_valid[i] & req_ready[i]; responses carry no backpressure.

  logic [IDW-1:0]  rr_q, rr_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic            found;
  logic            hs;
  logic [16:0]     mul_a_q;
  logic [7:0]      mul_b_q;
  logic            iss_vld_q;
  logic [IDW-1:0]  iss_id_q;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [IDW-1:0]  tag_id_q [MUL_LAT];
  logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [16:0]     rsp_data_q;

  // Rotating search from rr_q; with the priority build, slot 0 preempts and is skipped in the rotation.
  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
`ifdef MULT_SHARE_PRIO0_EN
    if (req_valid[0]) begin
      found  = 1'b1;
      win_id = '0;
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
`ifdef MULT_SHARE_PRIO0_EN
      if (!found && idx != 0 && req_valid[idx]) begin
`else
      if (!found && req_valid[idx]) begin
`endif
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
    if (found) grant[win_id] = 1'b1;
  end

  assign req_ready = grant & {NREQ{en & rst_n}};
  assign hs        = |(req_ready & req_valid);

  always_comb begin
    rr_d = rr_q;
`ifdef MULT_SHARE_PRIO0_EN
    if (hs && win_id != '0) begin
`else
    if (hs) begin
`endif
      rr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    end
  end

  always_comb begin
    rsp_vld_d = '0;
    if (tag_vld_q[MUL_LAT-1]) rsp_vld_d[tag_id_q[MUL_LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      iss_vld_q  <= 1'b0;
      iss_id_q   <= '0;
      tag_vld_q  <= '0;
      for (int k = 0; k < MUL_LAT; k++) tag_id_q[k] <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      rr_q      <= rr_d;
      mul_a_q   <= hs ? req_a[17*win_id +: 17] : 17'd0;
      mul_b_q   <= hs ? req_b[8*win_id +: 8] : 8'd0;
      iss_vld_q <= hs;
      iss_id_q  <= hs ? win_id : '0;
      // Tag stages track the multiplier pipeline so the ID lines up with mul_p.
      tag_vld_q[0] <= iss_vld_q;
      tag_id_q[0]  <= iss_id_q;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      rsp_vld_q <= rsp_vld_d;
      if (tag_vld_q[MUL_LAT-1]) rsp_data_q <= mul_p;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_vld_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = iss_vld_q | (|tag_vld_q) | (|rsp_vld_q);

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: driver pushes expected responses, a monitor pops and compares.
module tb_mult_share_arb;
  localparam int NREQ = 4, MUL_LAT = 4, IDW = 2, EW = 53;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [67:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [16:0] mul_a;
  logic [7:0]  mul_b;
  logic [16:0] mul_p;
  logic [3:0]  rsp_valid;
  logic [16:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit use_fixed = 1'b0;
  logic [16:0] fix_a = '0;
  logic [7:0]  fix_b = '0;
  logic [EW-1:0] exp_q[$];
  logic [16:0] mpipe [MUL_LAT];

  mult_share_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Q1.7 twiddle: full signed product shifted right by 7, low 17 bits kept.
  function automatic logic [16:0] ref_mul(input logic [16:0] a, input logic [7:0] b);
    logic signed [24:0] p;
    p = $signed(a) * $signed(b);
    return p[23:7];
  endfunction

  // Behavioural multiplier with MUL_LAT register stages.
  always @(posedge clk) begin
    mpipe[0] <= ref_mul(mul_a, mul_b);
    for (int k = 1; k < MUL_LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_p = mpipe[MUL_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Driver: one cycle of stimulus, check grant, push expected response.
  task automatic drive(input logic en_v, input logic [3:0] v, input int exp_id, input bit push = 1'b1);
    logic [16:0] a_now [4];
    logic [7:0]  b_now [4];
    logic [3:0]  oh;
    @(posedge clk);
    #1;
    en = en_v;
    req_valid = v;
    for (int i = 0; i < 4; i++) begin
      a_now[i] = use_fixed ? fix_a : 17'(cyc * 613 + i * 4099 + 77);
      b_now[i] = use_fixed ? fix_b : 8'(cyc * 29 + i * 71 + 3);
      req_a[17*i +: 17] = a_now[i];
      req_b[8*i +: 8]   = b_now[i];
    end
    @(negedge clk);
    oh = (exp_id < 0) ? 4'b0000 : 4'(1 << exp_id);
    chk("req_ready", 32'(req_ready), 32'(oh));
    if (exp_id >= 0 && push)
      exp_q.push_back({32'(cyc + 6), oh, ref_mul(a_now[exp_id], b_now[exp_id])});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b1;
    req_valid = 4'hF;
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40) begin
      drive(1'b1, 4'b0000, -1);
      n++;
    end
    chk("drain_in_budget", 32'(n < 40), 1);
    chk("busy_after_drain", 32'(busy), 0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid != 4'b0000) begin
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid %0h data %0h expected none (cycle %0d)",
                 rsp_valid, rsp_data, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", 32'(cyc), e[52:21]);
        chk("rsp_valid", 32'(rsp_valid), 32'(e[20:17]));
        chk("rsp_data", 32'(rsp_data), 32'(e[16:0]));
      end
    end
  end

  initial begin
    // 1: single request, hand-computed product, latency and busy
    do_reset();
    use_fixed = 1'b1;
    fix_a = 17'h04000;
    fix_b = 8'h40;
    drive(1'b1, 4'b0001, 0, 1'b0);
    exp_q.push_back({32'(cyc + 6), 4'b0001, 17'h02000});
    use_fixed = 1'b0;
    repeat (5) drive(1'b1, 4'b0000, -1);
    drive(1'b1, 4'b0000, -1);
    chk("t1_busy_c6", 32'(busy), 1);
    drive(1'b1, 4'b0000, -1);
    chk("t1_busy_c7", 32'(busy), 0);
    chk("t1_q_empty", 32'(exp_q.size()), 0);

    // 2: full contention
    do_reset();
    for (int k = 0; k < 8; k++) drive(1'b1, 4'b1111, k % 4);
    drain();

    // 3: pointer at 2, only 1 and 3 valid
    do_reset();
    drive(1'b1, 4'b0010, 1);
    drive(1'b1, 4'b1010, 3);
    drive(1'b1, 4'b1010, 1);
    drive(1'b1, 4'b1010, 3);
    drive(1'b1, 4'b1010, 1);
    drain();

    // 4: enable drops after three grants
    do_reset();
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1111, 1);
    drive(1'b1, 4'b1111, 2);
    repeat (3) drive(1'b0, 4'b1111, -1);
    drain();

    // 5: reset two cycles after a grant
    do_reset();
    drive(1'b1, 4'b0100, 2);
    drive(1'b1, 4'b0000, -1);
    drive(1'b1, 4'b0000, -1);
    do_reset();
    drive(1'b1, 4'b1010, 1);
    drain();

    // 6: requester 0 valid every other cycle, 1..3 always valid
    do_reset();
`ifdef MULT_SHARE_PRIO0_EN
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 1);
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 2);
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 3);
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 1);
`else
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 1);
    drive(1'b1, 4'b1111, 2);
    drive(1'b1, 4'b1110, 3);
    drive(1'b1, 4'b1111, 0);
    drive(1'b1, 4'b1110, 1);
    drive(1'b1, 4'b1111, 2);
    drive(1'b1, 4'b1110, 3);
`endif
    drain();

    chk("final_q_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
